// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if -- bundles the fetch buffer's instruction-memory, branch
// predictor, redirect and decode-side signals.
//
// Parameters:
//   XLEN  - PC / instruction width
//   DEPTH - fetch-queue entries (sets the occupancy width)
//
// Signals (direction as seen by the fetch buffer, modport master):
//   imem_req_valid, imem_req_addr          out : fetch request
//   imem_resp_inst                         in  : one-cycle-latency response
//   bp_taken, bp_btb_hit, bp_target        in  : prediction for imem_req_addr
//   redirect_valid, redirect_pc            in  : misprediction / PC redirect
//   out_valid, out_pc, out_inst,
//   out_pred_taken, out_next_pc_predicted,
//   out_pred_next_pc, occupancy            out : queue head towards decode
//   out_ready                              in  : decode accepts the head
// The slave modport is the environment's view (memory, predictor, decode).
interface fetch_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int OccW = $clog2(DEPTH) + 1;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic [XLEN-1:0] imem_resp_inst;
  logic            bp_taken;
  logic            bp_btb_hit;
  logic [XLEN-1:0] bp_target;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic            out_pred_taken;
  logic            out_next_pc_predicted;
  logic [XLEN-1:0] out_pred_next_pc;
  logic [OccW-1:0] occupancy;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_resp_inst,
    input  bp_taken, bp_btb_hit, bp_target,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_inst, out_pred_taken,
    output out_next_pc_predicted, out_pred_next_pc, occupancy,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_resp_inst,
    output bp_taken, bp_btb_hit, bp_target,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_inst, out_pred_taken,
    input  out_next_pc_predicted, out_pred_next_pc, occupancy,
    output out_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer -- instruction fetch front end with a small fetch queue.
// Issues one fetch per cycle while the queue has credit, follows BTB
// predictions, queues responses (which arrive one cycle after the request)
// together with their prediction info, and stalls in WAIT_REDIRECT when a
// branch is predicted taken without a BTB target until a redirect arrives.
// All state changes on the falling edge of clk.
//
// Ports:
//   clk  - clock, state updates on the falling edge
//   rst  - asynchronous, active-low reset
//   bus  - fetch_buffer_if.master: imem request/response, predictor inputs,
//          redirect, and the queue head / occupancy towards decode
module fetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              USE_BTB  = 1
) (
  input logic            clk,
  input logic            rst,
  fetch_buffer_if.master bus
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int OccW = PtrW + 1;
  localparam int CntW = OccW + 1;

  localparam logic [0:0] RUN           = 1'b0;
  localparam logic [0:0] WAIT_REDIRECT = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            predTaken;
    logic            nextPcPredicted;
    logic [XLEN-1:0] predNextPc;
  } entry_t;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflValid_q, inflValid_d;
  logic [XLEN-1:0] inflPc_q;
  logic [XLEN-1:0] inflTarget_q;
  logic            inflTaken_q;
  logic            inflHit_q;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [OccW-1:0] occ_q, occ_d;
  entry_t          mem_q [DEPTH];

  logic   btbHit;
  logic   predictRedirect;
  logic   credit;
  logic   reqRun;
  logic   enq;
  logic   deq;
  logic   respBranch;
  logic   missBranch;
  logic   outValid;
  entry_t respEntry;
  entry_t head;

  assign btbHit          = (USE_BTB != 0) && bus.bp_btb_hit;
  assign predictRedirect = bus.bp_taken && btbHit;

  // Credit counts the response still in flight, so the queue can never be
  // asked to accept an entry while full.
  assign credit = ({1'b0, occ_q} + CntW'(inflValid_q)) < CntW'(DEPTH);
  assign reqRun = (state_q == RUN) && !bus.redirect_valid && credit;

  // A redirect overrides every queue movement in its cycle.
  assign enq        = inflValid_q && !bus.redirect_valid;
  assign deq        = outValid && bus.out_ready && !bus.redirect_valid;
  assign respBranch = bus.imem_resp_inst[6];
  assign missBranch = enq && respBranch && inflTaken_q && !inflHit_q;

  // Build the queue entry for the returning response; prediction bits only
  // survive on instructions that really are branches.
  always_comb begin
    respEntry.pc              = inflPc_q;
    respEntry.inst            = bus.imem_resp_inst;
    respEntry.predTaken       = respBranch && inflTaken_q;
    respEntry.nextPcPredicted = respBranch && inflTaken_q && inflHit_q;
    respEntry.predNextPc      = inflTarget_q;
  end

  // Next-state logic: redirect first, then queue movement, then the fetch
  // decision. A predicted-taken branch without a BTB target squashes the
  // request issued alongside it and parks the pc on the squashed address.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inflValid_d = 1'b0;
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    occ_d       = occ_q;
    if (bus.redirect_valid) begin
      state_d = RUN;
      pc_d    = bus.redirect_pc;
      rdPtr_d = wrPtr_q;
      occ_d   = '0;
    end else begin
      if (deq) rdPtr_d = rdPtr_q + PtrW'(1);
      if (enq) wrPtr_d = wrPtr_q + PtrW'(1);
      occ_d = occ_q + OccW'(enq) - OccW'(deq);
      if (missBranch) begin
        state_d = WAIT_REDIRECT;
      end else if (reqRun) begin
        inflValid_d = 1'b1;
        pc_d        = predictRedirect ? bus.bp_target : pc_q + XLEN'(4);
      end
    end
  end

  // Control state, pointers and the inflight side register.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      inflValid_q  <= 1'b0;
      inflPc_q     <= '0;
      inflTarget_q <= '0;
      inflTaken_q  <= 1'b0;
      inflHit_q    <= 1'b0;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      occ_q        <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inflValid_q <= inflValid_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      occ_q       <= occ_d;
      if (inflValid_d) begin
        inflPc_q     <= pc_q;
        inflTarget_q <= bus.bp_target;
        inflTaken_q  <= bus.bp_taken;
        inflHit_q    <= btbHit;
      end
    end
  end

  // Queue storage needs no reset: occupancy alone decides what is valid.
  always_ff @(negedge clk) begin
    if (enq) mem_q[wrPtr_q] <= respEntry;
  end

  assign head     = mem_q[rdPtr_q];
  assign outValid = (occ_q != '0);

  // Head fields are forced to zero when empty, which also gives the required
  // all-zero outputs while in reset.
  assign bus.imem_req_valid        = reqRun && rst;
  assign bus.imem_req_addr         = pc_q;
  assign bus.out_valid             = outValid;
  assign bus.out_pc                = outValid ? head.pc : '0;
  assign bus.out_inst              = outValid ? head.inst : '0;
  assign bus.out_pred_taken        = outValid && head.predTaken;
  assign bus.out_next_pc_predicted = outValid && head.nextPcPredicted;
  assign bus.out_pred_next_pc      = outValid ? head.predNextPc : '0;
  assign bus.occupancy             = occ_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer -- self-checking bench for fetch_buffer.
// A queue-based reference model advances one step per falling edge from the
// inputs that were applied; a compare process checks every DUT output against
// it at each rising edge. Directed scenarios add literal expectations, then a
// long randomized run exercises stalls, redirects, predictions and resets.
module tb_fetch_buffer;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pt;
    logic        npp;
    logic [31:0] tgt;
  } entry_t;

  logic clk = 1'b1;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference model state
  entry_t      q[$];
  logic        mInflV = 1'b0;
  logic [31:0] mInflPc = 32'h0;
  logic [31:0] mInflTgt = 32'h0;
  logic        mInflTk = 1'b0;
  logic        mInflHit = 1'b0;
  logic [31:0] mPc = RESET_PC;
  logic        mWaiting = 1'b0;

  // Stimulus configuration
  logic        randMode = 1'b0;
  logic [31:0] bpAddr = 32'hFFFF_FFFF;
  logic [31:0] bpTgt = 32'h0;
  logic        bpTakenEn = 1'b0;
  logic        bpHitEn = 1'b0;
  logic [31:0] branchAddr = 32'hFFFF_FFFF;

  fetch_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fbIf ();

  fetch_buffer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .USE_BTB(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(fbIf)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a hash of the address; bit 6 marks branches.
  function automatic logic [31:0] instAt(input logic [31:0] a);
    logic [31:0] v;
    v = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    if (!randMode) v[6] = (a == branchAddr);
    return v;
  endfunction

  // Fetch is allowed when not waiting, no redirect, and queue + inflight has room.
  function automatic logic modelReq();
    return rst && !mWaiting && !fbIf.redirect_valid && ((q.size() + int'(mInflV)) < DEPTH);
  endfunction

  task automatic modelStep();
    entry_t e;
    logic   squash;
    logic   req;
    if (!rst) begin
      q.delete();
      mInflV = 1'b0;
      mPc = RESET_PC;
      mWaiting = 1'b0;
      return;
    end
    req = modelReq();
    if (fbIf.redirect_valid) begin
      q.delete();
      mInflV = 1'b0;
      mPc = fbIf.redirect_pc;
      mWaiting = 1'b0;
      return;
    end
    squash = 1'b0;
    if (q.size() > 0 && fbIf.out_ready) void'(q.pop_front());
    if (mInflV) begin
      e.pc   = mInflPc;
      e.inst = fbIf.imem_resp_inst;
      e.pt   = e.inst[6] && mInflTk;
      e.npp  = e.pt && mInflHit;
      e.tgt  = mInflTgt;
      q.push_back(e);
      if (e.pt && !mInflHit) begin
        squash = 1'b1;
        mWaiting = 1'b1;
      end
    end
    mInflV = 1'b0;
    if (req && !squash) begin
      mInflV   = 1'b1;
      mInflPc  = mPc;
      mInflTk  = fbIf.bp_taken;
      mInflHit = fbIf.bp_btb_hit;
      mInflTgt = fbIf.bp_target;
      mPc      = (fbIf.bp_taken && fbIf.bp_btb_hit) ? fbIf.bp_target : mPc + 32'd4;
    end
  endtask

  // Model advances just after each falling edge, from the inputs of the cycle that ended.
  always @(negedge clk) begin
    #1;
    modelStep();
  end

  // Compare every output against the model in mid-cycle.
  always @(posedge clk) begin
    if (!rst) begin
      check1("rst_req_valid", fbIf.imem_req_valid, 1'b0);
      check32("rst_req_addr", fbIf.imem_req_addr, RESET_PC);
      check1("rst_out_valid", fbIf.out_valid, 1'b0);
      check32("rst_occupancy", 32'(fbIf.occupancy), 32'd0);
      check1("rst_pred_taken", fbIf.out_pred_taken, 1'b0);
      check1("rst_npp", fbIf.out_next_pc_predicted, 1'b0);
      check32("rst_out_pc", fbIf.out_pc, 32'h0);
      check32("rst_out_inst", fbIf.out_inst, 32'h0);
      check32("rst_pred_next_pc", fbIf.out_pred_next_pc, 32'h0);
    end else begin
      check1("req_valid", fbIf.imem_req_valid, modelReq());
      check32("req_addr", fbIf.imem_req_addr, mPc);
      check32("occupancy", 32'(fbIf.occupancy), 32'(q.size()));
      check1("out_valid", fbIf.out_valid, q.size() != 0);
      if (q.size() > 0) begin
        check32("out_pc", fbIf.out_pc, q[0].pc);
        check32("out_inst", fbIf.out_inst, q[0].inst);
        check1("out_pred_taken", fbIf.out_pred_taken, q[0].pt);
        check1("out_npp", fbIf.out_next_pc_predicted, q[0].npp);
        if (q[0].npp) check32("out_pred_next_pc", fbIf.out_pred_next_pc, q[0].tgt);
      end else begin
        check1("empty_pred_taken", fbIf.out_pred_taken, 1'b0);
        check1("empty_npp", fbIf.out_next_pc_predicted, 1'b0);
      end
    end
  end

  // Memory response and predictor inputs, derived from the model's fetch state.
  task automatic applyStimulus();
    fbIf.imem_resp_inst = instAt(mInflPc);
    if (randMode) begin
      fbIf.bp_taken   = ($urandom_range(0, 3) == 0);
      fbIf.bp_btb_hit = 1'($urandom_range(0, 1));
      fbIf.bp_target  = 32'($urandom_range(0, 63)) << 2;
    end else begin
      fbIf.bp_taken   = (mPc == bpAddr) && bpTakenEn;
      fbIf.bp_btb_hit = (mPc == bpAddr) && bpHitEn;
      fbIf.bp_target  = bpTgt;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #2;
    applyStimulus();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    fbIf.imem_resp_inst = 32'h0;
    fbIf.bp_taken       = 1'b0;
    fbIf.bp_btb_hit     = 1'b0;
    fbIf.bp_target      = 32'h0;
    fbIf.redirect_valid = 1'b0;
    fbIf.redirect_pc    = 32'h0;
    fbIf.out_ready      = 1'b1;

    // Reset state and straight-line fetch
    cyc();
    settle();
    check1("reset_req_valid", fbIf.imem_req_valid, 1'b0);
    check32("reset_occupancy", 32'(fbIf.occupancy), 32'd0);
    cyc();
    rst = 1'b1;
    settle();
    check1("first_req_valid", fbIf.imem_req_valid, 1'b1);
    check32("first_req_addr", fbIf.imem_req_addr, 32'h0);
    cyc();
    settle();
    check32("second_req_addr", fbIf.imem_req_addr, 32'h4);
    check1("second_out_valid", fbIf.out_valid, 1'b0);
    cyc();
    settle();
    check32("line_out_pc0", fbIf.out_pc, 32'h0);
    check32("line_occ", 32'(fbIf.occupancy), 32'd1);
    check32("third_req_addr", fbIf.imem_req_addr, 32'h8);
    for (int i = 0; i < 6; i++) begin
      cyc();
      settle();
      check1("line_occ_le1", fbIf.occupancy <= 1, 1'b1);
    end

    // Decode stall: queue fills to DEPTH then drains in order
    fbIf.out_ready = 1'b0;
    doReset();
    for (int i = 0; i < 10; i++) cyc();
    settle();
    check32("stall_occ_full", 32'(fbIf.occupancy), 32'd4);
    check1("stall_no_req", fbIf.imem_req_valid, 1'b0);
    check32("stall_head", fbIf.out_pc, 32'h0);
    fbIf.out_ready = 1'b1;
    settle();
    for (int i = 0; i < 5; i++) begin
      check32("drain_order", fbIf.out_pc, 32'(i * 4));
      cyc();
      settle();
    end

    // BTB hit at pc 8
    bpAddr = 32'h8; bpTgt = 32'h40; bpTakenEn = 1'b1; bpHitEn = 1'b1; branchAddr = 32'h8;
    doReset();
    for (int i = 0; i < 3; i++) cyc();
    settle();
    check32("btb_next_req", fbIf.imem_req_addr, 32'h40);
    cyc();
    settle();
    check32("btb_head_pc", fbIf.out_pc, 32'h8);
    check1("btb_head_npp", fbIf.out_next_pc_predicted, 1'b1);
    check1("btb_head_pt", fbIf.out_pred_taken, 1'b1);
    check32("btb_head_tgt", fbIf.out_pred_next_pc, 32'h40);

    // Predicted-taken branch without BTB target: wait for redirect
    bpHitEn = 1'b0;
    doReset();
    for (int i = 0; i < 4; i++) cyc();
    fbIf.out_ready = 1'b0;
    settle();
    check1("wait_no_req", fbIf.imem_req_valid, 1'b0);
    check32("wait_pc_held", fbIf.imem_req_addr, 32'hC);
    check32("wait_head_pc", fbIf.out_pc, 32'h8);
    check1("wait_head_pt", fbIf.out_pred_taken, 1'b1);
    check1("wait_head_npp", fbIf.out_next_pc_predicted, 1'b0);
    for (int i = 0; i < 3; i++) cyc();
    settle();
    check1("wait_still_no_req", fbIf.imem_req_valid, 1'b0);
    check32("wait_occ", 32'(fbIf.occupancy), 32'd1);
    fbIf.redirect_valid = 1'b1;
    fbIf.redirect_pc = 32'h80;
    cyc();
    fbIf.redirect_valid = 1'b0;
    fbIf.out_ready = 1'b1;
    settle();
    check32("redir_flush", 32'(fbIf.occupancy), 32'd0);
    check1("redir_req_valid", fbIf.imem_req_valid, 1'b1);
    check32("redir_req_addr", fbIf.imem_req_addr, 32'h80);

    // Redirect with three entries queued and a response in flight, then a reset pulse
    bpAddr = 32'hFFFF_FFFF; branchAddr = 32'hFFFF_FFFF;
    fbIf.out_ready = 1'b0;
    doReset();
    for (int i = 0; i < 4; i++) cyc();
    settle();
    check32("pre_redir_occ", 32'(fbIf.occupancy), 32'd3);
    fbIf.redirect_valid = 1'b1;
    fbIf.redirect_pc = 32'h100;
    cyc();
    fbIf.redirect_valid = 1'b0;
    settle();
    check32("flush_occ", 32'(fbIf.occupancy), 32'd0);
    check32("flush_req_addr", fbIf.imem_req_addr, 32'h100);
    cyc();
    settle();
    check32("squashed_not_enq", 32'(fbIf.occupancy), 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    rst = 1'b0;
    settle();
    check32("midrst_occ", 32'(fbIf.occupancy), 32'd0);
    check1("midrst_req_valid", fbIf.imem_req_valid, 1'b0);
    cyc();
    rst = 1'b1;
    settle();
    check1("post_rst_req_valid", fbIf.imem_req_valid, 1'b1);
    check32("post_rst_req_addr", fbIf.imem_req_addr, RESET_PC);

    // Randomized traffic checked by the model
    randMode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      cyc();
      fbIf.out_ready = ($urandom_range(0, 3) != 0);
      if (mWaiting) fbIf.redirect_valid = ($urandom_range(0, 2) == 0);
      else fbIf.redirect_valid = ($urandom_range(0, 19) == 0);
      fbIf.redirect_pc = 32'($urandom_range(0, 255)) << 2;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
    end
    rst = 1'b1;
    fbIf.redirect_valid = 1'b0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XLEN, 32, PC and instruction width.
- DEPTH, 4, fetch-queue entries; power of two, at least 2.
- RESET_PC, 0, PC loaded at reset.
- USE_BTB, 1, when 0, bp_btb_hit is treated as 0.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the falling edge.
- rst, in, 1, asynchronous, active-low reset.
- imem_req_valid, out, 1, fetch request issued this cycle.
- imem_req_addr, out, XLEN, fetch address; equals the current pc.
- imem_resp_inst, in, XLEN, instruction for the previous cycle's request; fixed latency of one cycle.
- bp_taken, in, 1, direction prediction for imem_req_addr, same cycle.
- bp_btb_hit, in, 1, BTB hit for imem_req_addr, same cycle.
- bp_target, in, XLEN, BTB target for imem_req_addr.
- redirect_valid, in, 1, misprediction or irregular-PC redirect.
- redirect_pc, in, XLEN, redirect target.
- out_valid, out, 1, queue head valid.
- out_ready, in, 1, decode accepts the head; low means data/structural stall.
- out_pc, out, XLEN, head PC.
- out_inst, out, XLEN, head instruction.
- out_pred_taken, out, 1, head predicted taken.
- out_next_pc_predicted, out, 1, head's next PC came from the BTB.
- out_pred_next_pc, out, XLEN, BTB target recorded for the head.
- occupancy, out, clog2(DEPTH)+1, number of queue entries.

Function
REQ-003 State machine SHALL have two states, RUN and WAIT_REDIRECT; reset state is RUN.
REQ-004 In RUN, imem_req_valid SHALL be 1 iff redirect_valid=0 and occupancy + inflight < DEPTH, where inflight is 1 when a request was issued last cycle and not squashed.
REQ-005 On an issued request, the next pc SHALL be bp_target if bp_taken & bp_btb_hit, else pc+4 (modulo 2^XLEN).
- The request's pred_taken, next_pc_predicted and target SHALL be captured in an inflight side register.
REQ-006 A response SHALL be enqueued the cycle after its request unless squashed.
- Entry holds {pc, inst, pred_taken, next_pc_predicted, pred_next_pc}.
REQ-007 A response SHALL be a branch when inst[6]=1.
- A non-branch response SHALL have pred_taken and next_pc_predicted forced to 0.
REQ-008 If a response is a branch with bp_taken=1 and no BTB hit, the fetch buffer SHALL:
- enqueue it;
- squash any request issued in the same cycle;
- hold pc at the squashed address;
- enter WAIT_REDIRECT.
REQ-009 In WAIT_REDIRECT, imem_req_valid SHALL be 0; the queue SHALL continue to drain; only redirect_valid leaves the state.
REQ-010 When redirect_valid=1 in any state, on that edge the fetch buffer SHALL:
- flush the queue (occupancy=0);
- squash the inflight response;
- set pc=redirect_pc;
- enter RUN.
- The request for redirect_pc SHALL be issued the following cycle.
- Redirect SHALL take priority over enqueue, dequeue and stall.
REQ-011 Dequeue SHALL occur when out_valid & out_ready.
- out_valid = (occupancy != 0).
- Head fields are driven from registers, so an entry is visible the cycle after enqueue.
REQ-012 Simultaneous enqueue and dequeue SHALL leave occupancy unchanged.
- Read and write pointers SHALL wrap modulo DEPTH.
REQ-013 With out_ready=0, head fields and occupancy SHALL stay constant, except for enqueue of the inflight response.
- The credit rule in REQ-004 guarantees no overflow; enqueue when full SHALL never occur.
REQ-014 Queue empty SHALL give out_valid=0.
- Stale head fields are don't-care, but out_pred_taken and out_next_pc_predicted SHALL read 0 when empty.

Reset
REQ-015 While rst=0, asynchronously:
- pc=RESET_PC, state=RUN, occupancy=0, inflight=0.
- out_valid=0, imem_req_valid=0, out_pred_taken=0, out_next_pc_predicted=0.
- All other outputs SHALL be 0.
REQ-016 The first request SHALL be issued on the first falling edge after rst rises, with imem_req_addr=RESET_PC.
REQ-017 Reset asserted mid-operation SHALL discard queue contents, the inflight request and WAIT_REDIRECT state.

Verification
REQ-018 Straight-line code, out_ready=1: addresses 0,4,8,...; out_pc follows two cycles after each request; occupancy stays at most 1.
REQ-019 out_ready=0 for 10 cycles: occupancy saturates at DEPTH=4 with no drop or duplicate; requests stop; after release, out_pc reads 0,4,8,12,16 in order.
REQ-020 BTB hit at pc 8 (bp_taken=1, bp_btb_hit=1, bp_target=0x40): next request is 0x40; the entry at pc 8 shows out_next_pc_predicted=1 and out_pred_next_pc=0x40.
REQ-021 Branch at pc 8 predicted taken, no BTB hit: fetch buffer enters WAIT_REDIRECT and the request for 12 is squashed; redirect_pc=0x80 gives flush, then a request to 0x80 next cycle.
REQ-022 redirect_valid with 3 entries queued and out_ready=0: occupancy becomes 0 and the inflight response is not enqueued; repeat with rst pulsed mid-stream, after which the first request is RESET_PC.
